// File: rtl/ring_arb_pkg.sv
// Shared types and constants for the ring burst arbiter.
package ring_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int RING_W   = 7;
  localparam int HOME_BIT = 0;
  localparam int LAST_BIT = 6;

  localparam int N_DEF  = 4;
  localparam int LW_DEF = 3;

endpackage

// File: rtl/onehot_ring7.sv
// Seven-position one-hot step ring; rotates one position per adv and wraps bit 6 to bit 0.
module onehot_ring7
  import ring_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [RING_W-1:0] pos,
  output logic              mark
);

  logic [RING_W-1:0] pos_q;
  logic [RING_W-1:0] pos_d;

  // Rotate upward on adv, otherwise hold.
  always_comb begin
    pos_d = pos_q;
    if (adv) begin
      pos_d = {pos_q[RING_W-2:0], pos_q[LAST_BIT]};
    end
  end

  // Position register; reset parks the ring at home.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= RING_W'(1) << HOME_BIT;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos  = pos_q;
  assign mark = pos_q[HOME_BIT] | pos_q[LAST_BIT];

endmodule

// File: rtl/ring_burst_arbiter.sv
// Round-robin burst arbiter driving a shared one-hot step ring.
//
// state | meaning
// IDLE  | no grant held; pick next requester round-robin
// STEP  | grant held; advance the ring once per cycle
// DONE  | final grant cycle; pulse done, release grant
module ring_burst_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int LW = LW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*LW-1:0]   len,
  output logic [N-1:0]      gnt,
  output logic              busy,
  output logic              done,
  output logic [RING_W-1:0] ring_pos,
  output logic              mark
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q,   gnt_d;
  logic [LW-1:0]  rem_q,   rem_d;
  logic [PW-1:0]  ptr_q,   ptr_d;
  logic [PW:0]    pick;
  logic [PW-1:0]  win;
  logic           adv;

  // Search upward from ptr+1 (mod N); MSB of the result flags a hit.
  // Scanning from the far end lets the nearest candidate overwrite the others.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(p) + i) % N;
      if (r[idx]) begin
        res = {1'b1, PW'(idx)};
      end
    end
    return res;
  endfunction

  // Next-state, grant latch, burst countdown and ring advance.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    adv     = 1'b0;
    pick    = rr_pick(req, ptr_q);
    win     = pick[PW-1:0];
    case (state_q)
      IDLE: begin
        if (pick[PW]) begin
          rem_d   = len[int'(win)*LW +: LW];
          gnt_d   = N'(1) << win;
          ptr_d   = win;
          state_d = (rem_d != '0) ? STEP : DONE;
        end
      end
      STEP: begin
        adv   = 1'b1;
        rem_d = rem_q - LW'(1);
        if (rem_q == LW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter registers; pointer resets to N-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rem_q   <= '0;
      ptr_q   <= PW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = |gnt_q;
  assign done = (state_q == DONE);

  onehot_ring7 u_ring (
    .clk  (clk),
    .rst  (rst),
    .adv  (adv),
    .pos  (ring_pos),
    .mark (mark)
  );

endmodule

// File: tb/tb_ring_burst_arbiter.sv
// Directed self-checking bench for ring_burst_arbiter (N=4, LW=3).
module tb_ring_burst_arbiter;

  localparam int N  = 4;
  localparam int LW = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*LW-1:0] len;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          done;
  logic [6:0]    ring_pos;
  logic          mark;

  int n_checks;
  int n_fail;

  ring_burst_arbiter #(.N(N), .LW(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .len      (len),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .ring_pos (ring_pos),
    .mark     (mark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    len = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] g, input logic d, input logic [6:0] rp);
    check({tag, ".gnt"},  32'(gnt), 32'(g));
    check({tag, ".busy"}, 32'(busy), 32'(g != 4'b0));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".ring"}, 32'(ring_pos), 32'(rp));
    check({tag, ".mark"}, 32'(mark), 32'(rp[0] | rp[6]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    req = '0;
    len = '0;
    cyc();
    chk_state("reset", 4'b0000, 1'b0, 7'b0000001);
    cyc();
    rst = 1'b0;

    // len0 = 3 from home
    req = 4'b0001;
    len[0*LW +: LW] = 3'd3;
    cyc();
    req = '0;
    chk_state("b3.t1", 4'b0001, 1'b0, 7'b0000001);
    cyc(); chk_state("b3.t2", 4'b0001, 1'b0, 7'b0000010);
    cyc(); chk_state("b3.t3", 4'b0001, 1'b0, 7'b0000100);
    cyc(); chk_state("b3.t4", 4'b0001, 1'b1, 7'b0001000);
    cyc(); chk_state("b3.t5", 4'b0000, 1'b0, 7'b0001000);

    // all four requesting, len = 1: grants 0,1,2,3,0 every 3 cycles
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) len[i*LW +: LW] = 3'd1;
    for (int k = 0; k < 14; k++) begin
      cyc();
      check($sformatf("rr.gnt%0d", k), 32'(gnt),
            (k % 3 == 2) ? 32'd0 : (32'd1 << ((k / 3) % 4)));
      check($sformatf("rr.done%0d", k), 32'(done), 32'(k % 3 == 1));
    end
    req = '0;
    check("rr.ring", 32'(ring_pos), 32'b0100000);
    cyc();
    check("rr.idle", 32'(gnt), 32'd0);

    // len0 = 0: grant and done together, ring still
    do_reset();
    req = 4'b0001;
    len[0*LW +: LW] = 3'd0;
    cyc();
    req = '0;
    chk_state("z.t1", 4'b0001, 1'b1, 7'b0000001);
    cyc();
    chk_state("z.t2", 4'b0000, 1'b0, 7'b0000001);

    // len 6 reaches bit 6, then len 1 wraps home
    do_reset();
    req = 4'b0001;
    len[0*LW +: LW] = 3'd6;
    cyc();
    req = '0;
    for (int k = 2; k <= 6; k++) cyc();
    check("w6.done_early", 32'(done), 32'd0);
    cyc();
    chk_state("w6.t7", 4'b0001, 1'b1, 7'b1000000);
    cyc();
    req = 4'b0010;
    len[1*LW +: LW] = 3'd1;
    cyc();
    req = '0;
    chk_state("w1.t1", 4'b0010, 1'b0, 7'b1000000);
    cyc();
    chk_state("w1.t2", 4'b0010, 1'b1, 7'b0000001);

    // req dropped and len changed mid-burst are ignored
    do_reset();
    req = 4'b0001;
    len[0*LW +: LW] = 3'd4;
    cyc();
    req = '0;
    len[0*LW +: LW] = 3'd7;
    cyc(); cyc(); cyc();
    chk_state("ig.t4", 4'b0001, 1'b0, 7'b0001000);
    cyc();
    chk_state("ig.t5", 4'b0001, 1'b1, 7'b0010000);
    cyc();
    chk_state("ig.t6", 4'b0000, 1'b0, 7'b0010000);

    // reset during second step of a len 5 burst
    do_reset();
    req = 4'b0001;
    len[0*LW +: LW] = 3'd5;
    cyc();
    cyc();
    check("ab.pre_ring", 32'(ring_pos), 32'b0000010);
    rst = 1'b1;
    #1;
    chk_state("ab.rst", 4'b0000, 1'b0, 7'b0000001);
    req = 4'b1010;
    len[1*LW +: LW] = 3'd2;
    len[3*LW +: LW] = 3'd2;
    cyc();
    check("ab.hold_done", 32'(done), 32'd0);
    rst = 1'b0;
    cyc();
    req = '0;
    chk_state("ab.regrant", 4'b0010, 1'b0, 7'b0000001);
    cyc(); cyc();
    check("ab.done", 32'(done), 32'd1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
